// File: rtl/c2f_chunk_rcvr.sv
// CPU->FPGA chunk ring receiver: host QW writes land in a chunk RAM ring, consumer sees a FWFT 64-bit stream.
// Latency: last-QW commit at edge N -> rdValid_out after N+2; then 1 QW/cycle; chunk consume at M -> mtrReq_out after M+1.
// Backpressure: writes into a full ring are dropped (overflow_out pulse); rdReady_in low holds rdData_out; mtrAck_in low holds mtrReq_out.
//
// Ports:
//   pcieClk_in / reset_in            : clock, synchronous active-high reset
//   wrValid_in, wrAddr_in, wrData_in : host QW write, wrAddr_in = {chunk, offset}
//   rdData_out, rdValid_out, rdReady_in : FWFT read stream
//   mtrReq_out, mtrPtr_out, mtrAck_in   : read-pointer publish request (coalescing)
//   overflow_out                     : one-cycle pulse per dropped write
//   addrErr_out                      : sticky chunk-field error, only with C2F_RCVR_CHECK_EN defined
// Optional feature macro: C2F_RCVR_CHECK_EN (chunk-field check on writes).

module c2f_chunk_rcvr #(
  parameter int CHUNK_QWS  = 128,
  parameter int NUM_CHUNKS = 4
) (
  input  logic                                              pcieClk_in,
  input  logic                                              reset_in,
  input  logic                                              wrValid_in,
  input  logic [$clog2(NUM_CHUNKS)+$clog2(CHUNK_QWS)-1:0]   wrAddr_in,
  input  logic [63:0]                                       wrData_in,
  output logic [63:0]                                       rdData_out,
  output logic                                              rdValid_out,
  input  logic                                              rdReady_in,
  output logic                                              mtrReq_out,
  output logic [$clog2(NUM_CHUNKS)-1:0]                     mtrPtr_out,
  input  logic                                              mtrAck_in,
  output logic                                              overflow_out,
  output logic                                              addrErr_out
);

  localparam int CI    = $clog2(NUM_CHUNKS);
  localparam int QI    = $clog2(CHUNK_QWS);
  localparam int AW    = CI + QI;
  localparam int DEPTH = NUM_CHUNKS * CHUNK_QWS;
  localparam logic [QI-1:0] LAST_OFS = QI'(CHUNK_QWS - 1);

  // ---------------- write path ----------------
  logic [63:0]   mem [0:DEPTH-1];
  logic [CI-1:0] wr_ptr, wr_ptr_inc;
  logic [CI-1:0] wr_chunk;
  logic [QI-1:0] wr_ofs;
  logic          ring_full, chunk_ok, wr_store, wr_commit;

  assign wr_chunk   = wrAddr_in[AW-1:QI];
  assign wr_ofs     = wrAddr_in[QI-1:0];
  assign wr_ptr_inc = wr_ptr + CI'(1);

  // rd_ptr declared with the read path; full uses the pre-update pointers.
  logic [CI-1:0] rd_ptr;
  assign ring_full = (wr_ptr_inc == rd_ptr);

`ifdef C2F_RCVR_CHECK_EN
  assign chunk_ok = (wr_chunk == wr_ptr);
`else
  assign chunk_ok = 1'b1;
`endif

  assign wr_store  = wrValid_in && !ring_full && chunk_ok;
  // Host fills a chunk in ascending order, so its last QW marks it complete.
  assign wr_commit = wr_store && (wr_chunk == wr_ptr) && (wr_ofs == LAST_OFS);

  always_ff @(posedge pcieClk_in) begin
    if (wr_store) mem[wrAddr_in] <= wrData_in;
  end

  always_ff @(posedge pcieClk_in) begin
    if (reset_in) begin
      wr_ptr       <= '0;
      overflow_out <= 1'b0;
    end else begin
      overflow_out <= wrValid_in && ring_full;
      if (wr_commit) wr_ptr <= wr_ptr_inc;
    end
  end

`ifdef C2F_RCVR_CHECK_EN
  always_ff @(posedge pcieClk_in) begin
    if (reset_in)                                                 addrErr_out <= 1'b0;
    else if (wrValid_in && !ring_full && (wr_chunk != wr_ptr))    addrErr_out <= 1'b1;
  end
`else
  assign addrErr_out = 1'b0;
`endif

  // ---------------- read path ----------------
  // The fetch pointer runs up to two QWs ahead of the pop pointer {rd_ptr, rd_ofs}:
  // one QW in the output register, one in the RAM output register (the skid).
  // rd_ptr only advances when a chunk's last QW is actually popped, so the host
  // can never overwrite a chunk still held in the pipeline.
  typedef enum logic [1:0] {EMPTY, FETCH, VALID} pf_state_t;
  pf_state_t     pf_state, pf_state_nxt;
  logic          skid_vld, skid_vld_nxt;
  logic [CI-1:0] f_ptr;
  logic [QI-1:0] f_ofs, rd_ofs;
  logic [63:0]   ram_q;
  logic          out_vld, s1_vld, pop, out_free, load_out, issue, s1_nxt, out_nxt;
  logic          consume, consume_q;

  assign out_vld  = (pf_state == VALID);
  assign s1_vld   = (pf_state == FETCH) || skid_vld;
  assign pop      = out_vld && rdReady_in;
  assign out_free = !out_vld || pop;
  assign load_out = s1_vld && out_free;
  // Never fetch from the chunk still being written (f_ptr == wr_ptr).
  assign issue    = (f_ptr != wr_ptr) && (!s1_vld || out_free);
  assign s1_nxt   = issue || (s1_vld && !out_free);
  assign out_nxt  = (out_vld && !pop) || s1_vld;
  assign consume  = pop && (rd_ofs == LAST_OFS);

  always_comb begin
    pf_state_nxt = EMPTY;
    skid_vld_nxt = 1'b0;
    if (out_nxt) begin
      pf_state_nxt = VALID;
      skid_vld_nxt = s1_nxt;
    end else if (s1_nxt) begin
      pf_state_nxt = FETCH;
    end
  end

  always_ff @(posedge pcieClk_in) begin
    if (issue) ram_q <= mem[{f_ptr, f_ofs}];
  end

  always_ff @(posedge pcieClk_in) begin
    if (reset_in) begin
      pf_state   <= EMPTY;
      skid_vld   <= 1'b0;
      rdData_out <= '0;
      f_ptr      <= '0;
      f_ofs      <= '0;
      rd_ptr     <= '0;
      rd_ofs     <= '0;
      consume_q  <= 1'b0;
    end else begin
      pf_state  <= pf_state_nxt;
      skid_vld  <= skid_vld_nxt;
      consume_q <= consume;
      if (load_out) rdData_out <= ram_q;
      if (issue) begin
        f_ofs <= f_ofs + QI'(1);
        if (f_ofs == LAST_OFS) f_ptr <= f_ptr + CI'(1);
      end
      if (pop) begin
        rd_ofs <= rd_ofs + QI'(1);
        if (consume) rd_ptr <= rd_ptr + CI'(1);
      end
    end
  end

  assign rdValid_out = out_vld;

  // ---------------- metrics publish ----------------
  // consume_q lines up with the already-incremented rd_ptr, so it is the value published.
  typedef enum logic {IDLE, REQ} mtr_state_t;
  mtr_state_t mtr_state, mtr_state_nxt;

  always_comb begin
    mtr_state_nxt = mtr_state;
    case (mtr_state)
      IDLE:    if (consume_q) mtr_state_nxt = REQ;
      REQ:     if (!consume_q && mtrAck_in) mtr_state_nxt = IDLE;  // new increment wins over ack
      default: mtr_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge pcieClk_in) begin
    if (reset_in) begin
      mtr_state  <= IDLE;
      mtrPtr_out <= '0;
    end else begin
      mtr_state <= mtr_state_nxt;
      if (consume_q) mtrPtr_out <= rd_ptr;
    end
  end

  assign mtrReq_out = (mtr_state == REQ);

endmodule

// File: tb/tb_c2f_chunk_rcvr.sv
// Bench for c2f_chunk_rcvr: scoreboard queue filled at write time, drained by a read monitor.
// Latency: n/a (testbench).
// Backpressure: drives rdReady_in / mtrAck_in from scenario tasks.

module tb_c2f_chunk_rcvr;

  logic        clk = 1'b0;
  logic        rst, wr_vld, rd_rdy, mtr_ack;
  logic [8:0]  wr_addr;
  logic [63:0] wr_dat, rd_dat;
  logic        rd_vld, mtr_req, overflow, addr_err;
  logic [1:0]  mtr_ptr;

  int          errors = 0;
  int          checks = 0;
  int          pops   = 0;
  logic [63:0] exp_q[$];
  logic        hold_vld = 1'b0;
  logic [63:0] hold_dat;

`ifdef C2F_RCVR_CHECK_EN
  localparam logic EXP_ERR = 1'b1;
`else
  localparam logic EXP_ERR = 1'b0;
`endif

  always #5 clk = ~clk;

  c2f_chunk_rcvr dut (
    .pcieClk_in  (clk),
    .reset_in    (rst),
    .wrValid_in  (wr_vld),
    .wrAddr_in   (wr_addr),
    .wrData_in   (wr_dat),
    .rdData_out  (rd_dat),
    .rdValid_out (rd_vld),
    .rdReady_in  (rd_rdy),
    .mtrReq_out  (mtr_req),
    .mtrPtr_out  (mtr_ptr),
    .mtrAck_in   (mtr_ack),
    .overflow_out(overflow),
    .addrErr_out (addr_err)
  );

  function automatic logic [63:0] seq64(input int i);
    logic [31:0] a;
    a = i;
    return {(a * 32'h9E37_79B9) ^ 32'h5A5A_0000, ~a ^ (a << 7)};
  endfunction

  // Read monitor: inputs change only just after posedge, so negedge values predict the next edge.
  always @(negedge clk) begin
    if (rst) begin
      hold_vld = 1'b0;
    end else begin
      if (hold_vld) begin
        checks++;
        if (rd_vld !== 1'b1 || rd_dat !== hold_dat) begin
          errors++;
          $display("FAIL hold: vld=%b dat=%h, required vld=1 dat=%h", rd_vld, rd_dat, hold_dat);
        end
      end
      hold_vld = rd_vld && !rd_rdy;
      hold_dat = rd_dat;
      if (rd_vld === 1'b1 && rd_rdy) begin
        pops++;
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL pop_unexpected: got %h, required no data", rd_dat);
        end else begin
          logic [63:0] e;
          e = exp_q.pop_front();
          if (rd_dat !== e) begin
            errors++;
            $display("FAIL pop_data: got %h, required %h", rd_dat, e);
          end
        end
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
    $fatal(1, "watchdog");
  end

  task automatic do_reset();
    rst = 1'b1; wr_vld = 1'b0; rd_rdy = 1'b0; mtr_ack = 1'b0;
    wr_addr = '0; wr_dat = '0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    exp_q.delete();
    pops = 0;
  endtask

  task automatic wr(input int chunk, input int ofs, input logic [63:0] d);
    logic [1:0] c;
    logic [6:0] o;
    c = chunk[1:0];
    o = ofs[6:0];
    wr_vld = 1'b1; wr_addr = {c, o}; wr_dat = d;
    @(posedge clk);
    #1;
    wr_vld = 1'b0;
  endtask

  task automatic drain(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      if (exp_q.size() == 0) begin ok = 1'b1; break; end
      @(posedge clk);
      #1;
    end
    if (exp_q.size() == 0) ok = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    checks += 6;
    if (rd_vld   !== 1'b0) begin errors++; $display("FAIL rst_rdValid: got %b, required 0", rd_vld); end
    if (rd_dat   !== '0)   begin errors++; $display("FAIL rst_rdData: got %h, required 0", rd_dat); end
    if (mtr_req  !== 1'b0) begin errors++; $display("FAIL rst_mtrReq: got %b, required 0", mtr_req); end
    if (mtr_ptr  !== 2'd0) begin errors++; $display("FAIL rst_mtrPtr: got %0d, required 0", mtr_ptr); end
    if (overflow !== 1'b0) begin errors++; $display("FAIL rst_overflow: got %b, required 0", overflow); end
    if (addr_err !== 1'b0) begin errors++; $display("FAIL rst_addrErr: got %b, required 0", addr_err); end
  endtask

  task automatic test_basic();
    bit ok;
    do_reset();
    for (int i = 0; i < 128; i++) begin
      exp_q.push_back(seq64(i));
      wr(0, i, seq64(i));
    end
    @(posedge clk); #1;
    checks++;
    if (rd_vld !== 1'b0) begin errors++; $display("FAIL basic_lat_n1: rdValid=%b, required 0", rd_vld); end
    @(posedge clk); #1;
    checks++;
    if (rd_vld !== 1'b1) begin errors++; $display("FAIL basic_lat_n2: rdValid=%b, required 1", rd_vld); end
    rd_rdy = 1'b1;
    drain(300, ok);
    checks++;
    if (!ok || pops != 128) begin errors++; $display("FAIL basic_drain: pops=%0d left=%0d, required 128/0", pops, exp_q.size()); end
    for (int i = 0; i < 10 && !mtr_req; i++) begin @(posedge clk); #1; end
    checks += 2;
    if (mtr_req !== 1'b1) begin errors++; $display("FAIL basic_mtrReq: got %b, required 1", mtr_req); end
    if (mtr_ptr !== 2'd1) begin errors++; $display("FAIL basic_mtrPtr: got %0d, required 1", mtr_ptr); end
    checks++;
    if (rd_vld !== 1'b0) begin errors++; $display("FAIL basic_empty: rdValid=%b, required 0", rd_vld); end
  endtask

  task automatic test_overflow();
    bit ok;
    do_reset();
    for (int c = 0; c < 3; c++)
      for (int o = 0; o < 128; o++) begin
        exp_q.push_back(seq64(c * 128 + o));
        wr(c, o, seq64(c * 128 + o));
      end
    for (int o = 0; o < 128; o++) begin
      wr(3, o, seq64(384 + o));
      checks++;
      if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_pulse[%0d]: got %b, required 1", o, overflow); end
    end
    @(posedge clk); #1;
    checks++;
    if (overflow !== 1'b0) begin errors++; $display("FAIL ovf_clear: got %b, required 0", overflow); end
    rd_rdy = 1'b1;
    drain(500, ok);
    repeat (10) @(posedge clk);
    #1;
    checks += 2;
    if (!ok || pops != 384) begin errors++; $display("FAIL ovf_count: pops=%0d, required 384", pops); end
    if (rd_vld !== 1'b0) begin errors++; $display("FAIL ovf_empty: rdValid=%b, required 0", rd_vld); end
  endtask

  task automatic test_stream();
    bit        ok;
    bit        done;
    logic [1:0] pub[$];
    do_reset();
    rd_rdy = 1'b1;
    done = 1'b0;
    fork
      begin
        for (int c = 0; c < 6; c++)
          for (int o = 0; o < 128; o++) begin
            exp_q.push_back(seq64(2000 + c * 128 + o));
            wr(c % 4, o, seq64(2000 + c * 128 + o));
          end
        drain(300, ok);
        repeat (10) @(posedge clk);
        done = 1'b1;
      end
      begin
        while (!done) begin
          @(posedge clk); #1;
          if (mtr_req && !mtr_ack) begin
            pub.push_back(mtr_ptr);
            mtr_ack = 1'b1;
          end else begin
            mtr_ack = 1'b0;
          end
        end
      end
    join
    mtr_ack = 1'b0;
    checks += 2;
    if (!ok || pops != 768) begin errors++; $display("FAIL stream_count: pops=%0d, required 768", pops); end
    if (pub.size() != 6) begin errors++; $display("FAIL stream_pub_n: got %0d publishes, required 6", pub.size()); end
    for (int i = 0; i < 6 && i < pub.size(); i++) begin
      logic [1:0] e;
      e = 2'((i + 1) % 4);
      checks++;
      if (pub[i] !== e) begin errors++; $display("FAIL stream_pub[%0d]: got %0d, required %0d", i, pub[i], e); end
    end
  endtask

  task automatic test_random_ready();
    int budget;
    do_reset();
    for (int c = 0; c < 2; c++)
      for (int o = 0; o < 128; o++) begin
        exp_q.push_back(seq64(5000 + c * 128 + o));
        rd_rdy = 1'($urandom_range(0, 1));
        wr(c, o, seq64(5000 + c * 128 + o));
      end
    budget = 2000;
    while (exp_q.size() != 0 && budget > 0) begin
      rd_rdy = 1'($urandom_range(0, 1));
      @(posedge clk); #1;
      budget--;
    end
    rd_rdy = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    checks++;
    if (pops != 256 || exp_q.size() != 0) begin
      errors++; $display("FAIL rand_count: pops=%0d left=%0d, required 256/0", pops, exp_q.size());
    end
  endtask

  task automatic test_coalesce();
    bit ok;
    bit dropped;
    do_reset();
    for (int c = 0; c < 2; c++)
      for (int o = 0; o < 128; o++) begin
        exp_q.push_back(seq64(7000 + c * 128 + o));
        wr(c, o, seq64(7000 + c * 128 + o));
      end
    rd_rdy = 1'b1;
    for (int i = 0; i < 300 && !mtr_req; i++) begin @(posedge clk); #1; end
    checks += 2;
    if (mtr_req !== 1'b1) begin errors++; $display("FAIL coal_req1: got %b, required 1", mtr_req); end
    if (mtr_ptr !== 2'd1) begin errors++; $display("FAIL coal_ptr1: got %0d, required 1", mtr_ptr); end
    dropped = 1'b0;
    for (int i = 0; i < 300 && mtr_ptr == 2'd1; i++) begin
      @(posedge clk); #1;
      if (mtr_req !== 1'b1) dropped = 1'b1;
    end
    checks += 3;
    if (dropped) begin errors++; $display("FAIL coal_hold: mtrReq dropped=1, required 0"); end
    if (mtr_ptr !== 2'd2) begin errors++; $display("FAIL coal_ptr2: got %0d, required 2", mtr_ptr); end
    if (mtr_req !== 1'b1) begin errors++; $display("FAIL coal_req2: got %b, required 1", mtr_req); end
    drain(50, ok);
    checks++;
    if (!ok || pops != 256) begin errors++; $display("FAIL coal_count: pops=%0d, required 256", pops); end
    mtr_ack = 1'b1;
    @(posedge clk); #1;
    mtr_ack = 1'b0;
    checks++;
    if (mtr_req !== 1'b0) begin errors++; $display("FAIL coal_ack: mtrReq=%b, required 0", mtr_req); end
    dropped = 1'b0;
    repeat (20) begin
      @(posedge clk); #1;
      if (mtr_req !== 1'b0) dropped = 1'b1;
    end
    checks++;
    if (dropped) begin errors++; $display("FAIL coal_no_second: extra request=1, required 0"); end
  endtask

  task automatic test_reset_mid();
    bit ok;
    do_reset();
    for (int o = 0; o < 64; o++) wr(0, o, 64'hDEAD_0000_0000_0000 | 64'(o));
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    for (int o = 0; o < 128; o++) begin
      exp_q.push_back(seq64(9000 + o));
      wr(0, o, seq64(9000 + o));
    end
    rd_rdy = 1'b1;
    drain(300, ok);
    repeat (10) @(posedge clk);
    #1;
    checks += 2;
    if (!ok || pops != 128) begin errors++; $display("FAIL rstmid_count: pops=%0d, required 128", pops); end
    if (rd_vld !== 1'b0) begin errors++; $display("FAIL rstmid_empty: rdValid=%b, required 0", rd_vld); end
  endtask

  task automatic test_addr_check();
    do_reset();
    for (int o = 0; o < 128; o++) wr(2, o, seq64(11000 + o));
    rd_rdy = 1'b1;
    repeat (20) @(posedge clk);
    #1;
    checks += 3;
    if (addr_err !== EXP_ERR) begin errors++; $display("FAIL addr_err: got %b, required %b", addr_err, EXP_ERR); end
    if (rd_vld !== 1'b0) begin errors++; $display("FAIL addr_nodata: rdValid=%b, required 0", rd_vld); end
    if (pops != 0) begin errors++; $display("FAIL addr_pops: got %0d, required 0", pops); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_overflow();
    test_stream();
    test_random_ready();
    test_coalesce();
    test_reset_mid();
    test_addr_check();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
